// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable serial pattern detector (pattern, length, overlap mode).
// Latency: dout is combinational in the cycle the last pattern bit arrives; dout_q follows one clock later.
// Backpressure: none; din is sampled only when din_valid is high, and idle cycles stall the history.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               dout,
  output logic               dout_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

  // Control state and latched configuration
  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic               armed_q;
  logic               cfg_err_q;

  // Stream history: newest bit in hist_q[0]; fill_q counts bits usable for the next match
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [LW-1:0]      fill_q;
  logic [LW-1:0]      fill_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Match evaluation
  logic               cfg_legal;
  logic               accept;
  logic               fill_ok;
  logic               pat_hit;
  logic               cnt_sat;
  logic [LW:0]        fill_p1;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] window;

  // The oldest history bit is shifted out before it could ever be compared: the
  // incoming din always supplies the final pattern bit, so at most MAX_LEN-1
  // stored bits take part in a match.
  logic               hist_msb_unused;
  assign hist_msb_unused = hist_q[MAX_LEN-1];

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= FILL_MAX);

  // A bit is consumed only while running; a load in the same cycle wins over data
  assign accept = (state_q == RUN) && din_valid && !cfg_load;

  // Enough history once the stored bits plus the incoming one cover the pattern
  assign fill_p1 = {1'b0, fill_q} + (LW + 1)'(1);
  assign fill_ok = fill_p1 >= {1'b0, len_q};

  // Candidate window: stored history with the incoming bit appended as the newest
  assign window = {hist_q[MAX_LEN-2:0], din};

  // Mask selecting the low len_q pattern bits; upper pattern bits are ignored
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  assign pat_hit = ((window ^ pat_q) & len_mask) == '0;

  assign dout    = accept && fill_ok && pat_hit;
  assign cnt_sat = &cnt_q;

  // Next history, fill level and counter for a load, an accepted bit, or a hold
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      hist_d = {hist_q[MAX_LEN-2:0], din};
      if (dout && !ovl_q) begin
        // Non-overlapping: bits that formed this match cannot seed the next one
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LW'(1);
      end
      if (dout && !cnt_sat) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Control FSM: a load selects RUN or ERR and latches the configuration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      armed_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
      if (cfg_legal) begin
        state_q   <= RUN;
        armed_q   <= 1'b1;
        cfg_err_q <= 1'b0;
      end else begin
        state_q   <= ERR;
        armed_q   <= 1'b0;
        cfg_err_q <= 1'b1;
      end
    end
  end

  // History, fill, counter and registered match; dout is low during a load so dout_q clears too
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      dout_q <= dout;
    end
  end

  assign match_count = cnt_q;
  assign armed       = armed_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
// Two instances share stimulus: 8-bit counter and 2-bit counter (saturation).
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;

  logic       dout_a, dq_a, err_a, arm_a;
  logic [7:0] cnt_a;
  logic       dout_b, dq_b, err_b, arm_b;
  logic [1:0] cnt_b;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
    .dout(dout_a), .dout_q(dq_a), .match_count(cnt_a), .cfg_err(err_a), .armed(arm_a)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
    .dout(dout_b), .dout_q(dq_b), .match_count(cnt_b), .cfg_err(err_b), .armed(arm_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 run, 2 err. m_q holds the received bits still usable for a match.
  int                 m_st;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_q[$];
  int                 m_c8;
  int                 m_c2;
  bit                 m_dq;

  task automatic m_reset();
    m_st  = 0;
    m_pat = '0;
    m_len = 0;
    m_ovl = 1'b0;
    m_q.delete();
    m_c8  = 0;
    m_c2  = 0;
    m_dq  = 1'b0;
  endtask

  // Does the last (len-1) usable bits followed by din spell the pattern, first bit first?
  function automatic bit m_match();
    int base;
    bit got;
    if (m_st != 1 || din_valid !== 1'b1 || cfg_load !== 1'b0) return 1'b0;
    if (m_q.size() < m_len - 1) return 1'b0;
    base = m_q.size() - (m_len - 1);
    for (int k = 0; k < m_len; k++) begin
      got = (k == m_len - 1) ? din : m_q[base + k];
      if (got != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial m_reset();

  always @(negedge reset_n) m_reset();

  always @(posedge clk) begin : model_step
    bit m;
    if (reset_n === 1'b1) begin
      m = m_match();
      m_dq = m;
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        m_st  = (m_len >= 1 && m_len <= MAX_LEN) ? 1 : 2;
        m_q.delete();
        m_c8  = 0;
        m_c2  = 0;
        m_dq  = 1'b0;
      end else if (m_st == 1 && din_valid) begin
        m_q.push_back(din);
        if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
        if (m) begin
          if (!m_ovl) m_q.delete();
          if (m_c8 < 255) m_c8++;
          if (m_c2 < 3) m_c2++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout",       dout_a, m_match());
      check("dout_q",     dq_a,   m_dq);
      check("count",      cnt_a,  m_c8);
      check("cfg_err",    err_a,  m_st == 2);
      check("armed",      arm_a,  m_st == 1);
      check("dout_w2",    dout_b, m_match());
      check("dout_q_w2",  dq_b,   m_dq);
      check("count_w2",   cnt_b,  m_c2);
      check("cfg_err_w2", err_b,  m_st == 2);
      check("armed_w2",   arm_b,  m_st == 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  // A load cycle also presents a valid '1' that must be ignored
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    @(posedge clk); #1;
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    din_valid   = 1'b1;
    din         = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cfg_load  = 1'b0;
      din_valid = 1'b0;
      din       = 1'b0;
    end
  endtask

  task automatic send(input int b, input int exp_d, input string nm);
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    din_valid = 1'b1;
    din       = b[0];
    #3;
    check(nm, dout_a, exp_d);
  endtask

  int s_bits[7]  = '{1, 0, 1, 1, 0, 1, 1};
  int s1_d[7]    = '{0, 0, 0, 1, 0, 0, 0};
  int s1_dq[7]   = '{0, 0, 0, 0, 1, 0, 0};
  int s2_d[7]    = '{0, 0, 0, 1, 0, 0, 1};
  int s5_cnt[5]  = '{0, 1, 2, 3, 3};
  int s7_bits[12] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0};
  int s7_d[12]    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int s4_bits[4] = '{1, 0, 1, 1};
  int s6_pre[7]  = '{1, 0, 1, 1, 1, 0, 1};
  int s6_pd[7]   = '{0, 0, 0, 1, 0, 0, 0};

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_dout",    dout_a, 0);
    check("rst_dout_q",  dq_a,   0);
    check("rst_count",   cnt_a,  0);
    check("rst_cfg_err", err_a,  0);
    check("rst_armed",   arm_a,  0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // 1: 1011, non-overlapping; upper pattern bits are junk and must be ignored
    load(8'b1101_1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(s_bits[i], s1_d[i], "s1_dout");
      check("s1_dout_q", dq_a, s1_dq[i]);
    end
    idle(1);
    check("s1_count", cnt_a, 1);
    check("s1_armed", arm_a, 1);

    // 2: same stream, overlapping
    load(8'b0000_1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(s_bits[i], s2_d[i], "s2_dout");
      check("s2_dout_q", dq_a, s1_dq[i]);
    end
    idle(1);
    check("s2_dout_q_last", dq_a, 1);
    check("s2_count", cnt_a, 2);

    // 3: three invalid cycles between every bit
    load(8'b0000_1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(s_bits[i], s1_d[i], "s3_dout");
      for (int g = 0; g < 3; g++) begin
        idle(1);
        #3 check("s3_gap_dout", dout_a, 0);
      end
    end
    check("s3_count", cnt_a, 1);

    // 4: illegal lengths 0 and MAX_LEN+1, then a legal load
    load(8'b0000_1011, 4'd0, 1'b0);
    idle(1);
    check("s4_err_len0",   err_a, 1);
    check("s4_armed_len0", arm_a, 0);
    for (int i = 0; i < 4; i++) send(s4_bits[i], 0, "s4_dout_len0");
    load(8'b0000_1011, 4'd9, 1'b0);
    idle(1);
    check("s4_err_len9",   err_a, 1);
    check("s4_armed_len9", arm_a, 0);
    for (int i = 0; i < 4; i++) send(s4_bits[i], 0, "s4_dout_len9");
    check("s4_count_err", cnt_a, 0);
    load(8'b0000_1011, 4'd4, 1'b0);
    idle(1);
    check("s4_err_legal",   err_a, 0);
    check("s4_armed_legal", arm_a, 1);

    // 5: len 1, pattern bit 1, overlap; 2-bit counter saturates at 3
    load(8'b1010_0001, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1, 1, "s5_dout");
      check("s5_dout_w2", dout_b, 1);
      check("s5_count_w2", cnt_b, s5_cnt[i]);
    end
    idle(1);
    check("s5_count_w2_final", cnt_b, 3);
    check("s5_count_final", cnt_a, 5);
    check("s5_dout_q_w2", dq_b, 1);

    // 7: full-length pattern with fill saturating before the match
    load(8'b1100_1010, 4'd8, 1'b0);
    for (int i = 0; i < 12; i++) send(s7_bits[i], s7_d[i], "s7_dout");
    idle(1);
    check("s7_count", cnt_a, 1);

    // 6a: async reset while the last pattern bit is being presented
    load(8'b0000_1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) send(s6_pre[i], s6_pd[i], "s6_pre_dout");
    send(1, 1, "s6_mid_dout");
    reset_n = 1'b0;
    #1;
    check("s6_rst_dout",  dout_a, 0);
    check("s6_rst_dq",    dq_a,   0);
    check("s6_rst_count", cnt_a,  0);
    check("s6_rst_armed", arm_a,  0);
    check("s6_rst_err",   err_a,  0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send(1, 0, "s6_post_rst_dout");
    load(8'b0000_1011, 4'd4, 1'b0);
    send(0, 0, "s6_fresh0");
    send(1, 0, "s6_fresh1");
    send(1, 0, "s6_fresh2");
    send(1, 0, "s6_fresh3");
    send(0, 0, "s6_fresh4");
    send(1, 0, "s6_fresh5");
    send(1, 1, "s6_fresh6");

    // 6b: reload mid-match clears history
    load(8'b0000_1011, 4'd4, 1'b0);
    send(1, 0, "s6b_pre0");
    send(0, 0, "s6b_pre1");
    send(1, 0, "s6b_pre2");
    load(8'b0000_1011, 4'd4, 1'b0);
    send(1, 0, "s6b_post0");
    send(0, 0, "s6b_post1");
    send(1, 0, "s6b_post2");
    send(1, 1, "s6b_post3");
    idle(2);
    check("s6b_count", cnt_a, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable serial sequence detector. It is the next generation of the fixed-pattern Mealy detector. Pattern, pattern length and overlap mode are loaded at run time, and input is qualified by a valid strobe. It provides both a Mealy (same-cycle) and a registered match output, plus a saturating match counter. It sits on a serial bit stream and flags each occurrence of the programmed pattern to downstream control logic.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (legal range 2..32).
- CNT_W, 8, width of the match counter.
- LW, $clog2(MAX_LEN+1), width of the length fields (derived; do not override).

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern. Bit [cfg_len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  LW  pattern length; legal values are 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- din_valid  in  1  qualifies din in the current cycle.
- din  in  1  serial data bit.
- dout  out  1  Mealy match. Combinational; high in the cycle in which the last pattern bit is presented.
- dout_q  out  1  dout registered; one-cycle pulse one clock later.
- match_count  out  CNT_W  number of matches, saturating at all-ones.
- cfg_err  out  1  high while the latched configuration is illegal.
- armed  out  1  high while a legal configuration is active (state RUN).

## Operation
- State machine states: IDLE, RUN, ERR.
- State transitions:
  - Reset → IDLE.
  - Any state, on cfg_load with 1 ≤ cfg_len ≤ MAX_LEN → RUN.
  - Any state, on cfg_load with any other cfg_len → ERR.
  - No other transitions.
- Internal registers:
  - pat_r, len_r, ovl_r: latched configuration.
  - hist: MAX_LEN-bit shift register; the newest bit is hist[0].
  - fill: number of valid history bits, width LW, saturating at MAX_LEN.
- cfg_load effects:
  - Latches the configuration and clears hist, fill, match_count and dout_q.
  - din_valid in the same cycle as cfg_load is ignored.
- Match condition (Mealy): all of the following must hold.
  - state == RUN and din_valid = 1 and cfg_load = 0.
  - fill ≥ len_r-1.
  - {hist[len_r-2:0], din} == pat_r[len_r-1:0].
  - For len_r = 1, the condition reduces to din == pat_r[0].
- Accepted bit (din_valid in RUN, no cfg_load):
  - hist ← {hist[MAX_LEN-2:0], din}.
  - fill ← min(fill+1, MAX_LEN).
  - On a match with ovl_r = 0: fill ← 0, so the next match uses only bits received after this one.
  - On a match with ovl_r = 1: fill is not reset.
- On a match, match_count increments by 1 unless it is already all-ones.
- Cycles with din_valid = 0 change nothing. Gaps in din_valid do not break a partial match.
- In IDLE and ERR:
  - dout = 0, and hist, fill and match_count hold.
  - cfg_err = (state == ERR).
- Only pat_r[len_r-1:0] is compared; the upper pattern bits are don't-care.

## Timing
- Reset values: dout = 0, dout_q = 0, match_count = 0, cfg_err = 0, armed = 0, state = IDLE, hist = 0, fill = 0, configuration registers = 0.
- Reset is asynchronous on assertion and acts immediately mid-stream, including mid-match. Deassertion is sampled at the next rising edge.
- dout has zero latency: it is combinational from din, din_valid, cfg_load and registered state. No input-to-output flop is required.
- dout_q and match_count update on the rising edge that accepts the matching bit.
- cfg_load takes effect at the edge on which it is sampled. The first usable bit is the next valid cycle.
- Counter saturation: at all-ones, further matches still pulse dout and dout_q, but the count holds.

## Test plan
1. Load pattern 4'b1011, len=4, overlap=0; stream 1,0,1,1,0,1,1 one bit per cycle → dout is high only on bit 3; dout_q is high one cycle later; match_count = 1.
2. Same stream with overlap=1 → dout is high on bits 3 and 6; match_count = 2.
3. len=4, pattern 1011, with din_valid=0 for 3 cycles between every bit → the same match positions as scenario 1; no matches appear during the gaps.
4. Load cfg_len=0, then cfg_len=MAX_LEN+1 → cfg_err=1, armed=0, dout stays 0 under any stream. A following legal load → cfg_err=0, armed=1.
5. CNT_W=2, len=1, pattern 1, overlap=1; stream five 1s → dout is high on all five bits; match_count goes 1, 2, 3, 3, 3.
6. Mid-stream events:
   - After receiving 1,0,1 of pattern 1011, assert reset_n=0 between clock edges → all outputs are 0 immediately, and a subsequent 1 produces no match.
   - Repeat with cfg_load instead of reset → history is cleared, and 1,0,1,1 is needed afresh for a match.
